filter_seq: RTL and testbench

FILTER_SEQ -- requirements
Module: filter_seq

---
 rtl/filter_seq.sv | 147 ++++++++++++++
 tb/tb_filter_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_seq.sv
// Sample sequencer: queues incoming samples in a small FIFO and feeds them one at a
// time to a filter engine, holding each result until downstream accepts it.
module filter_seq #(
   parameter int IN_B    = 16,
   parameter int OUT_B   = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [IN_B-1:0]  s_data,
   input  logic             s_valid,
   output logic [IN_B-1:0]  eng_in_data,
   output logic             eng_in_valid,
   input  logic [OUT_B-1:0] eng_out_data,
   input  logic             eng_out_valid,
   output logic [OUT_B-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [15:0]      overrun_cnt,
   output logic             timeout_err,
   input  logic             clr_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [PW:0]   FULL_LVL  = (PW + 1)'(DEPTH);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   logic [1:0]      state;
   logic [IN_B-1:0] mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW:0]     count;
   logic [CW-1:0]   wait_cnt;
   logic            full;
   logic            push;
   logic            drop;
   logic            pop;
   logic            expire;

   // Fullness is judged before any same-cycle pop, so a push onto a full FIFO drops.
   assign full   = (count == FULL_LVL);
   assign push   = s_valid && !full;
   assign drop   = s_valid && full;
   assign pop    = (state == IDLE) && (count != '0) && !m_valid;
   assign expire = (state == WAIT) && !eng_out_valid && (wait_cnt == LAST_WAIT);

   assign eng_in_valid = (state == ISSUE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + (PW + 1)'(1);
         end else if (pop && !push) begin
            count <= count - (PW + 1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         eng_in_data <= '0;
         m_data      <= '0;
         m_valid     <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  eng_in_data <= mem[rd_ptr];
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (eng_out_valid) begin
                  m_data  <= eng_out_data;
                  m_valid <= 1'b1;
                  state   <= HOLD;
               end else if (expire) begin
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            HOLD: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A set event in the same cycle as clr_err wins: flag stays set, counter restarts at 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_cnt <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (drop) begin
            if (clr_err) begin
               overrun_cnt <= 16'd1;
            end else if (overrun_cnt != 16'hFFFF) begin
               overrun_cnt <= overrun_cnt + 16'd1;
            end
         end else if (clr_err) begin
            overrun_cnt <= '0;
         end

         if (expire) begin
            timeout_err <= 1'b1;
         end else if (clr_err) begin
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_filter_seq.sv
// Scoreboard bench for filter_seq: an engine stub answers issued samples with a fixed
// transform; expected results are queued at stimulus time and matched on each transfer.
module tb_filter_seq;

   logic        clk;
   logic        reset_n;
   logic [15:0] s_data;
   logic        s_valid;
   logic [15:0] eng_in_data;
   logic        eng_in_valid;
   logic [31:0] eng_out_data;
   logic        eng_out_valid;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] overrun_cnt;
   logic        timeout_err;
   logic        clr_err;

   filter_seq #(
      .IN_B(16),
      .OUT_B(32),
      .DEPTH(4),
      .TIMEOUT(64)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .s_data(s_data),
      .s_valid(s_valid),
      .eng_in_data(eng_in_data),
      .eng_in_valid(eng_in_valid),
      .eng_out_data(eng_out_data),
      .eng_out_valid(eng_out_valid),
      .m_data(m_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .overrun_cnt(overrun_cnt),
      .timeout_err(timeout_err),
      .clr_err(clr_err)
   );

   int          checks;
   int          errors;
   int          xfers;
   int          issues;
   int          lat;
   int          spur_cnt;
   bit          stub_answer;
   bit          outstanding;
   bit          to_prev;
   logic [31:0] exp_q[$];
   logic [15:0] iss_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] eng_model(input logic [15:0] d);
      return {~d, d} + 32'h0001_3579;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Engine stub: answers lat cycles after an issue, or injects a spurious strobe on request.
   initial begin
      int          spur_done;
      int          l;
      logic [15:0] d;
      spur_done     = 0;
      eng_out_valid = 1'b0;
      eng_out_data  = '0;
      forever begin
         @(negedge clk);
         if (spur_cnt != spur_done) begin
            spur_done     = spur_cnt;
            eng_out_data  = 32'hDEAD_BEEF;
            eng_out_valid = 1'b1;
            @(negedge clk);
            eng_out_valid = 1'b0;
         end else if (eng_in_valid && stub_answer) begin
            d = eng_in_data;
            l = lat;
            repeat (l - 1) @(posedge clk);
            #1;
            eng_out_data  = eng_model(d);
            eng_out_valid = 1'b1;
            @(posedge clk);
            #1;
            eng_out_valid = 1'b0;
         end
      end
   end

   // Monitor: issue ordering, single outstanding sample, and result scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            outstanding = 1'b0;
         end else begin
            if (eng_in_valid) begin
               check("one_outstanding", 32'(outstanding), 32'd0);
               outstanding = 1'b1;
               issues++;
               check("issue_expected", 32'(iss_q.size() != 0), 32'd1);
               if (iss_q.size() != 0) begin
                  check("eng_in_data", 32'(eng_in_data), 32'(iss_q.pop_front()));
               end
            end
            if (eng_out_valid || (timeout_err && !to_prev)) begin
               outstanding = 1'b0;
            end
            if (m_valid && m_ready) begin
               xfers++;
               check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  check("m_data", m_data, exp_q.pop_front());
               end
            end
         end
         to_prev = timeout_err;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input bit iss, input bit res);
      s_data  = d;
      s_valid = 1'b1;
      if (iss) iss_q.push_back(d);
      if (res) exp_q.push_back(eng_model(d));
      tick();
      s_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int max);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || iss_q.size() != 0) && n < max) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(tag, 32'(exp_q.size() + iss_q.size()), 32'd0);
      tick();
   endtask

   task automatic wait_mvalid(input string tag, input int max);
      int n;
      n = 0;
      while (!m_valid && n < max) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(m_valid), 32'd1);
   endtask

   task automatic wait_issue(input string tag, input int base, input int max);
      int n;
      n = 0;
      while (issues == base && n < max) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(tag, 32'(issues != base), 32'd1);
   endtask

   initial begin
      int          xb;
      int          ib;
      int          bad;
      logic [31:0] held;
      time         t0;
      time         t1;

      checks = 0; errors = 0; xfers = 0; issues = 0; spur_cnt = 0;
      lat = 9; stub_answer = 1'b1; outstanding = 1'b0; to_prev = 1'b0;
      reset_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; clr_err = 1'b0;
      repeat (3) tick();
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", m_data, 32'd0);
      check("rst_eng_in_valid", 32'(eng_in_valid), 32'd0);
      check("rst_eng_in_data", 32'(eng_in_data), 32'd0);
      check("rst_overrun", 32'(overrun_cnt), 32'd0);
      check("rst_timeout", 32'(timeout_err), 32'd0);
      reset_n = 1'b1;
      tick();

      // Single sample through a 9-cycle engine
      m_ready = 1'b1; xb = xfers; ib = issues;
      send(16'h1234, 1'b1, 1'b1);
      wait_drain("single_drain", 100);
      check("single_issues", 32'(issues - ib), 32'd1);
      check("single_xfers", 32'(xfers - xb), 32'd1);
      check("single_in_data", 32'(eng_in_data), 32'h1234);

      // Burst of six: first is popped at once, four queue, sixth drops
      xb = xfers; ib = issues;
      for (int i = 0; i < 6; i++) begin
         send(16'h0100 + 16'(i), i < 5, i < 5);
      end
      check("burst_overrun", 32'(overrun_cnt), 32'd1);
      wait_drain("burst_drain", 300);
      check("burst_xfers", 32'(xfers - xb), 32'd5);
      check("burst_issues", 32'(issues - ib), 32'd5);

      // Backpressure: result held, no issue until transfer, then issue resumes
      m_ready = 1'b0; lat = 3;
      send(16'hA5A5, 1'b1, 1'b1);
      send(16'h5A5A, 1'b1, 1'b1);
      wait_mvalid("bp_mvalid", 50);
      check("bp_first_data", m_data, eng_model(16'hA5A5));
      held = m_data; ib = issues; bad = 0;
      tick();
      repeat (20) begin
         @(negedge clk);
         if (m_data !== held || !m_valid) bad++;
      end
      check("bp_hold_stable", 32'(bad), 32'd0);
      check("bp_no_issue", 32'(issues - ib), 32'd0);
      tick();
      m_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_idle_gap", 32'(eng_in_valid), 32'd0);
      @(negedge clk);
      check("bp_resume_issue", 32'(eng_in_valid), 32'd1);
      tick();
      wait_drain("bp_drain", 60);

      // Engine never answers the first sample; the queued second one follows
      stub_answer = 1'b0; lat = 3;
      send(16'h0BAD, 1'b1, 1'b0);
      bad = 0;
      while (!eng_in_valid && bad < 10) begin
         @(negedge clk);
         bad++;
      end
      t0 = $time;
      tick();
      stub_answer = 1'b1;
      send(16'h600D, 1'b1, 1'b1);
      bad = 0;
      while (!timeout_err && bad < 200) begin
         @(negedge clk);
         bad++;
      end
      t1 = $time;
      check("to_cycles", 32'((t1 - t0) / 10), 32'd65);
      check("to_set", 32'(timeout_err), 32'd1);
      tick();
      wait_drain("to_drain", 60);
      check("to_sticky", 32'(timeout_err), 32'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("to_cleared", 32'(timeout_err), 32'd0);

      // Full FIFO: push+pop collision drops, set beats clear, counter saturates
      m_ready = 1'b0; lat = 2; xb = xfers;
      send(16'h0001, 1'b1, 1'b1);
      wait_mvalid("full_mvalid", 30);
      tick();
      for (int i = 0; i < 4; i++) begin
         send(16'h0010 + 16'(i), 1'b1, 1'b1);
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("full_clr", 32'(overrun_cnt), 32'd0);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      s_data  = 16'hBAD0;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      check("full_push_pop_drop", 32'(overrun_cnt), 32'd1);
      send(16'h0020, 1'b1, 1'b1);
      s_data  = 16'hDEAD;
      s_valid = 1'b1;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("set_beats_clr", 32'(overrun_cnt), 32'd1);
      repeat (65533) @(posedge clk);
      #1;
      check("sat_below", 32'(overrun_cnt), 32'hFFFE);
      @(posedge clk);
      #1;
      check("sat_reach", 32'(overrun_cnt), 32'hFFFF);
      repeat (3) @(posedge clk);
      #1;
      check("sat_hold", 32'(overrun_cnt), 32'hFFFF);
      s_valid = 1'b0;
      m_ready = 1'b1;
      wait_drain("full_drain", 300);
      check("full_xfers", 32'(xfers - xb), 32'd6);

      // Spurious strobe in IDLE, then reset while waiting on a slow engine
      xb = xfers;
      spur_cnt++;
      repeat (5) tick();
      check("spur_m_valid", 32'(m_valid), 32'd0);
      check("spur_xfers", 32'(xfers - xb), 32'd0);
      lat = 30; ib = issues;
      send(16'h7E57, 1'b1, 1'b0);
      wait_issue("rw_issue", ib, 20);
      tick();
      repeat (5) tick();
      reset_n = 1'b0;
      #1;
      check("rw_m_valid", 32'(m_valid), 32'd0);
      check("rw_m_data", m_data, 32'd0);
      check("rw_eng_in_valid", 32'(eng_in_valid), 32'd0);
      check("rw_eng_in_data", 32'(eng_in_data), 32'd0);
      check("rw_overrun", 32'(overrun_cnt), 32'd0);
      check("rw_timeout", 32'(timeout_err), 32'd0);
      iss_q.delete();
      exp_q.delete();
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (40) tick();
      check("rw_late_ignored", 32'(m_valid), 32'd0);
      check("rw_late_xfers", 32'(xfers - xb), 32'd0);
      check("rw_fifo_empty", 32'(issues - ib), 32'd1);
      lat = 3;
      send(16'h0C0D, 1'b1, 1'b1);
      wait_drain("rw_after_drain", 60);
      check("rw_after_xfers", 32'(xfers - xb), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
